// File: rtl/flash_arbiter.sv
// flash_arbiter: round-robin sharing of the toggle-driven flash read engine between
// the boot copier (port 0) and the CPU load path (port 1).
module flash_arbiter #(
  parameter int WAIT_CYCLES = 229376
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [21:0] addr0,
  input  logic [21:0] addr1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [21:0] flash_addr,
  output logic        read_ctrl,
  input  logic [15:0] flash_rdata
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [17:0] LOAD = 18'(WAIT_CYCLES - 1);
  logic [1:0] state;
  logic [17:0] cnt;
  logic last, cur, pick;
  // on a tie the port that was not served last wins
  assign pick = (req0 && req1) ? ~last : req1;
  assign busy = state != S_IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      rdata      <= 16'h0000;
      flash_addr <= 22'd0;
      read_ctrl  <= 1'b0;
      cnt        <= 18'd0;
      last       <= 1'b1;
      cur        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req0 || req1) begin
          flash_addr <= pick ? addr1 : addr0;
          cur        <= pick;
          gnt0       <= ~pick;
          gnt1       <= pick;
          state      <= S_ISSUE;
        end
        S_ISSUE: begin
          read_ctrl <= ~read_ctrl;
          cnt       <= LOAD;
          state     <= S_WAIT;
        end
        S_WAIT: if (cnt == 18'd0) begin
          rdata <= flash_rdata;
          done0 <= ~cur;
          done1 <= cur;
          state <= S_DONE;
        end else begin
          cnt <= cnt - 18'd1;
        end
        default: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          last  <= cur;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_flash_arbiter.sv
// tb_flash_arbiter: vector table, directed corner sequences and a randomized run
// against a transaction-level model of the arbiter.
module tb_flash_arbiter;
  localparam int W = 4;
  localparam logic [21:0] A0 = 22'h012345;
  localparam logic [21:0] A1 = 22'h0ABCDE;
  logic clk = 1'b0, rst = 1'b0, req0 = 1'b0, req1 = 1'b0;
  logic [21:0] addr0 = '0, addr1 = '0;
  logic [15:0] flash_rdata = '0;
  logic gnt0, gnt1, done0, done1, busy, read_ctrl;
  logic [15:0] rdata;
  logic [21:0] flash_addr;
  logic [5:0] ctl;
  int total = 0, passed = 0;
  typedef struct {
    logic r0, r1;
    logic [15:0] fd;
    logic [5:0] ctl;
    logic [21:0] fa;
    logic [15:0] rd;
  } vec_t;
  vec_t tbl[22];
  flash_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata), .busy(busy),
    .flash_addr(flash_addr), .read_ctrl(read_ctrl), .flash_rdata(flash_rdata)
  );
  assign ctl = {gnt0, gnt1, done0, done1, busy, read_ctrl};
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic logic sig(input int w);
    return w == 0 ? gnt0 : w == 1 ? gnt1 : w == 2 ? done0 : done1;
  endfunction
  task automatic wait_for(input int w, input string name);
    for (int n = 0; n < 20 && sig(w) !== 1'b1; n++) @(negedge clk);
    chk(name, 32'(sig(w)), 1);
  endtask
  function automatic vec_t mk(input logic r0, input logic r1, input logic [15:0] fd,
                              input logic [5:0] c, input logic [21:0] fa, input logic [15:0] rd);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.fd = fd; v.ctl = c; v.fa = fa; v.rd = rd;
    return v;
  endfunction
  initial begin
    #2000000 $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int cnt;
    bit m_act, m_own, m_last, m_rc, md;
    logic [15:0] m_rd;
    logic [21:0] m_fa;
    int e, m_g;
    logic r[2];
    logic [21:0] a[2];
    // ctl = {gnt0, gnt1, done0, done1, busy, read_ctrl}
    tbl[1] = mk(1, 1, 16'hBEEF, 6'b100010, A0, 16'h0000);
    for (int i = 2; i <= 5; i++) tbl[i] = mk(1, 1, 16'hBEEF, 6'b100011, A0, 16'h0000);
    tbl[6] = mk(1, 1, 16'hBEEF, 6'b101011, A0, 16'hBEEF);
    tbl[7] = mk(0, 1, 16'hBEEF, 6'b000001, A0, 16'hBEEF);
    tbl[8] = mk(1, 1, 16'h1234, 6'b010011, A1, 16'hBEEF);
    for (int i = 9; i <= 12; i++) tbl[i] = mk(1, 1, 16'h1234, 6'b010010, A1, 16'hBEEF);
    tbl[13] = mk(1, 1, 16'h1234, 6'b010110, A1, 16'h1234);
    tbl[14] = mk(1, 0, 16'h1234, 6'b000000, A1, 16'h1234);
    tbl[15] = mk(1, 1, 16'h5A5A, 6'b100010, A0, 16'h1234);
    for (int i = 16; i <= 19; i++) tbl[i] = mk(1, 1, 16'h5A5A, 6'b100011, A0, 16'h1234);
    tbl[20] = mk(1, 1, 16'h5A5A, 6'b101011, A0, 16'h5A5A);
    tbl[21] = mk(0, 1, 16'h5A5A, 6'b000001, A0, 16'h5A5A);
    req0 = 1; req1 = 1; addr0 = A0; addr1 = A1;
    repeat (2) @(negedge clk);
    chk("reset_ctl", 32'(ctl), 0);
    chk("reset_addr", 32'(flash_addr), 0);
    chk("reset_rdata", 32'(rdata), 0);
    rst = 1;
    for (int i = 1; i <= 21; i++) begin
      req0 = tbl[i].r0; req1 = tbl[i].r1; flash_rdata = tbl[i].fd;
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(tbl[i].ctl));
      chk($sformatf("vec%0d_addr", i), 32'(flash_addr), 32'(tbl[i].fa));
      chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(tbl[i].rd));
    end
    req0 = 0; req1 = 0;
    // address changes while owning the engine must not reach flash_addr
    req0 = 1; addr0 = 22'h000777;
    @(negedge clk);
    wait_for(0, "addr_grant");
    chk("addr_latched", 32'(flash_addr), 32'h777);
    addr0 = 22'h3FFFFF;
    for (int i = 0; i < 20 && done0 !== 1'b1; i++) begin
      @(negedge clk);
      chk("addr_frozen", 32'(flash_addr), 32'h777);
    end
    chk("addr_done", 32'(done0), 1);
    req0 = 0;
    @(negedge clk);
    chk("addr_idle_hold", 32'(flash_addr), 32'h777);
    req0 = 1;
    @(negedge clk);
    chk("addr_regrant", 32'(flash_addr), 32'h3FFFFF);
    wait_for(2, "addr_done2");
    req0 = 0;
    @(negedge clk);
    req1 = 1; addr1 = 22'h155555; flash_rdata = 16'hA5A5;
    @(negedge clk);
    wait_for(1, "wd_grant");
    repeat (2) @(negedge clk);
    req1 = 0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      cnt += int'(done1);
    end
    chk("wd_done_count", 32'(cnt), 1);
    chk("wd_idle", 32'({busy, gnt1}), 0);
    chk("wd_rdata", 32'(rdata), 32'hA5A5);
    req1 = 1; addr1 = 22'h02AAAA; flash_rdata = 16'h1111;
    @(negedge clk);
    wait_for(1, "rst_grant");
    repeat (2) @(negedge clk);
    chk("rst_pre_parity", 32'(read_ctrl), 1);
    #2 rst = 0;
    #1 chk("rst_async", 32'(ctl), 0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold", 32'(ctl), 0);
    end
    flash_rdata = 16'hC0DE;
    rst = 1;
    wait_for(3, "rst_redo_done");
    chk("rst_redo_rdata", 32'(rdata), 32'hC0DE);
    chk("rst_redo_addr", 32'(flash_addr), 32'h02AAAA);
    req1 = 0;
    // randomized traffic against the transaction-level model
    rst = 0; req0 = 0; req1 = 0;
    repeat (2) @(negedge clk);
    m_act = 0; m_own = 0; m_last = 1; m_rc = 0; m_rd = 0; m_fa = 0; e = 0; m_g = 0;
    r[0] = 0; r[1] = 0; a[0] = 0; a[1] = 0;
    rst = 1;
    for (int n = 0; n < 3000; n++) begin
      md = m_act && (e - m_g == W + 1);
      for (int p = 0; p < 2; p++) begin
        if (md && int'(m_own) == p) r[p] = 0;
        else if (r[p]) begin
          if (m_act && int'(m_own) == p) begin
            if ($urandom_range(15) == 0) r[p] = 0;
            if ($urandom_range(7) == 0) a[p] = 22'($urandom);
          end
        end else if ($urandom_range(2) == 0) begin
          r[p] = 1; a[p] = 22'($urandom);
        end
      end
      req0 = r[0]; req1 = r[1]; addr0 = a[0]; addr1 = a[1];
      flash_rdata = 16'($urandom);
      e++;
      if (m_act) begin
        if (e - m_g == 1) m_rc = ~m_rc;
        if (e - m_g == W + 1) m_rd = flash_rdata;
        if (e - m_g == W + 2) begin m_act = 0; m_last = m_own; end
      end else if (req0 || req1) begin
        m_own = (req0 && req1) ? ~m_last : req1;
        m_act = 1; m_g = e; m_fa = m_own ? addr1 : addr0;
      end
      md = m_act && (e - m_g == W + 1);
      @(negedge clk);
      chk("rand_ctl", 32'(ctl), 32'({m_act && !m_own, m_act && m_own, md && !m_own, md && m_own, m_act, m_rc}));
      chk("rand_addr", 32'(flash_addr), 32'(m_fa));
      chk("rand_rdata", 32'(rdata), 32'(m_rd));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/flash_arbiter.md
# flash_arbiter

Shares the single word-wide flash read engine between two requesters: port 0 is the boot image copier and port 1 is the CPU's flash-mapped load path. Each read is issued by latching an address and toggling the engine's `read_ctrl` line. The arbiter then waits a fixed, parameterised number of cycles covering the engine's slow internal sequence, and captures the returned word. Arbitration is round-robin, and completion is signalled to the winning port with a one-cycle `done` pulse.

## Interface
- `WAIT_CYCLES`, default 229376 (7 × 32768 engine ticks). Cycles from the `read_ctrl` toggle to data capture. Legal range is 1..262143. Benches override it with small values.
- `clk`  in  1  system clock; all logic on the rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `req0`, `req1`  in  1 each  read request, level; held high with a stable address until `done` is seen
- `addr0`, `addr1`  in  22 each  word address [22:1] for the port's request
- `gnt0`, `gnt1`  out  1 each  port owns the engine; high from address latch until `done`
- `done0`, `done1`  out  1 each  one-cycle pulse; `rdata` is valid in the same cycle
- `rdata`  out  16  last captured word; shared by both ports and held until the next capture
- `busy`  out  1  high in every state except IDLE
- `flash_addr`  out  22  to the engine address input [22:1]
- `read_ctrl`  out  1  toggle-request line to the engine; each transition requests one read
- `flash_rdata`  in  16  engine data output

## Operation
- **States:** IDLE, ISSUE, WAIT, DONE. Encoding is free. A 2-bit register is sufficient.
- **Reset:** while `rst` is low, all of the following hold:
  - state = IDLE
  - `gnt0`/`gnt1` = 0, `done0`/`done1` = 0, `busy` = 0
  - `rdata` = 16'h0000, `flash_addr` = 0, `read_ctrl` = 0
  - counter = 0
  - `last` = 1, so port 0 wins the first tie
- **IDLE:**
  - No request: stay in IDLE.
  - Exactly one request: grant that port.
  - Both requests: grant the port ≠ `last`.
  - On grant: latch that port's address into `flash_addr`, set its `gnt`, go to ISSUE.
- **ISSUE:** invert `read_ctrl`, load counter with `WAIT_CYCLES`−1, go to WAIT.
- **WAIT:**
  - If counter = 0: capture `flash_rdata` into `rdata`, assert the granted port's `done`, go to DONE.
  - Otherwise: decrement the counter.
- **DONE:**
  - Clear `done` and `gnt`.
  - Set `last` = the port just served.
  - Go to IDLE.
- **Address stability:** `flash_addr` is frozen from the grant edge until the next grant. Requester address changes during a transaction are ignored.
- **Request withdrawn mid-transaction:** the transaction still completes and `done` still pulses. The port may ignore it. No abort path exists.
- **Re-requests:** the requester must deassert `req` in the cycle after `done`. A `req` still high when IDLE samples it is a new request.
- **Exclusivity:** `gnt0` and `gnt1` are never high together, and neither are `done0` and `done1`.
- **Toggle parity:** `read_ctrl` toggles exactly once per transaction, so its parity equals the number of issued reads modulo 2.
- **Reset mid-operation:** the state machine returns to IDLE immediately. No `done` pulse is emitted, and `read_ctrl` is forced to 0. The engine has no reset and tracks toggle parity, so `rst` must coincide with power-up or an engine restart. Otherwise a stale toggle may launch one spurious engine read. The arbiter itself must not lock up in that case.

## Timing
- Let E0 be the rising edge at which IDLE samples a request.
- **Edge by edge:**
  - After E0: `gnt`, `busy` and `flash_addr` are valid.
  - At E1: `read_ctrl` toggles.
  - At E1+`WAIT_CYCLES`: capture; `done` is high for the following cycle only.
  - At E2+`WAIT_CYCLES`: IDLE.
- **Latency:** request-sample edge to visible `done` is `WAIT_CYCLES`+1 edges.
- **Throughput:** back-to-back reads from the same or alternating ports take `WAIT_CYCLES`+3 cycles each.
- `busy` falls in the same cycle `gnt` falls.
- The counter is 18 bits wide. There is no wrap-around, because the load value is at most 262142.

## Test plan
- **Reset values:** hold `rst` low with `req0`=`req1`=1. Require all outputs 0, `busy`=0 and `read_ctrl`=0. After release, require port 0 granted at the first edge.
- **Single read:** `WAIT_CYCLES`=4; `req0`=1, `addr0`=22'h12345; model returns 16'hBEEF.
  - `read_ctrl` goes 0→1 one edge after grant.
  - `done0` pulses 5 edges after E0, with `rdata`=16'hBEEF.
  - `flash_addr`=22'h12345 throughout.
- **Simultaneous requests:** `WAIT_CYCLES`=4; `req0` and `req1` held continuously and dropped for one cycle after each `done`.
  - Grants alternate 0,1,0,1.
  - `read_ctrl` toggles once per grant.
  - Consecutive `done` pulses are exactly 7 cycles apart.
- **Request withdrawn:** `req1` dropped during WAIT. Require the transaction to finish, `done1` to pulse once, then IDLE with `busy`=0.
- **Address change ignored:** change `addr0` to 22'h3FFFFF mid-transaction. Require `flash_addr` to stay at the original value until the next grant.
- **Reset mid-operation:** assert `rst` during WAIT. Require:
  - state is IDLE and `read_ctrl`=0 immediately, with no `done`;
  - after release, a new `req1` completes normally with the correct data.
